// File: rtl/vga_digit_sched_pkg.sv
// Shared VGA timing constants, load FSM encoding and coordinate helpers
// for the multiplexed seven-segment digit scheduler.
package vga_digit_sched_pkg;

    localparam int H_TOTAL = 800;
    localparam int V_TOTAL = 525;
    localparam int COORD_W = 10;

    typedef enum logic {
        LOAD_IDLE    = 1'b0,
        LOAD_PENDING = 1'b1
    } load_state_t;

    // Increment a raster coordinate, wrapping at the end of its range.
    function automatic logic [COORD_W-1:0] wrap_inc(input logic [COORD_W-1:0] value,
                                                    input int total);
        return (int'(value) == total - 1) ? '0 : value + COORD_W'(1);
    endfunction

endpackage

// File: rtl/vga_slot_locator.sv
// Maps a raster coordinate onto the digit slot whose box contains it,
// reporting the slot index, an in-box flag and the slot's left column.
module vga_slot_locator
    import vga_digit_sched_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 40,
    parameter int DIGIT_H    = 60,
    parameter int GAP        = 20,
    parameter int ORIGIN_X   = 200,
    parameter int ORIGIN_Y   = 200,
    parameter int SLOT_W     = 2
) (
    input  logic [COORD_W-1:0] h_next,
    input  logic [COORD_W-1:0] v_next,
    output logic [SLOT_W-1:0]  slot,
    output logic               in_box,
    output logic [COORD_W-1:0] slot_x
);

    localparam int PITCH = DIGIT_W + GAP;

    logic v_hit;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        slot   = '0;
        in_box = 1'b0;
        slot_x = COORD_W'(ORIGIN_X);
        v_hit  = (int'(v_next) >= ORIGIN_Y) && (int'(v_next) <= ORIGIN_Y + DIGIT_H);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (v_hit && (int'(h_next) >= ORIGIN_X + k * PITCH)
                      && (int'(h_next) <= ORIGIN_X + k * PITCH + DIGIT_W)) begin
                slot   = SLOT_W'(k);
                in_box = 1'b1;
                slot_x = COORD_W'(ORIGIN_X + k * PITCH);
            end
        end
    end

endmodule

// File: rtl/vga_digit_sched.sv
// Time-multiplexes one digit renderer across NUM_DIGITS screen slots, with
// frame-synchronous digit loading, blinking and leading-zero blanking.
module vga_digit_sched
    import vga_digit_sched_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_W      = 40,
    parameter int DIGIT_H      = 60,
    parameter int GAP          = 20,
    parameter int ORIGIN_X     = 200,
    parameter int ORIGIN_Y     = 200,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [9:0]              h_counter,
    input  logic [9:0]              v_counter,
    input  logic                    wr_valid,
    input  logic [4*NUM_DIGITS-1:0] wr_data,
    output logic                    wr_ready,
    input  logic                    blink_en,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    lz_suppress,
    output logic                    enable,
    output logic [3:0]              bcd,
    output logic [9:0]              h_start,
    output logic [9:0]              v_start,
    output logic [9:0]              h_size,
    output logic [9:0]              v_size,
    output logic                    frame_tick
);

    localparam int SLOT_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int WORD_W  = 4 * NUM_DIGITS;

    load_state_t           state, state_nxt;
    logic [WORD_W-1:0]     shadow_word, active_word;
    logic [BLINK_W-1:0]    blink_cnt;
    logic                  blink_on;
    logic [9:0]            h_next, v_next;
    logic                  tick_next;
    logic [SLOT_W-1:0]     slot;
    logic                  in_box;
    logic [9:0]            slot_x;
    logic [3:0]            digit;
    logic [NUM_DIGITS-1:0] lead_zero;
    logic                  blank;
    logic                  capture, commit;

    // Outputs are registered, so everything is evaluated for the pixel after this one.
    assign h_next    = wrap_inc(h_counter, H_TOTAL);
    assign v_next    = (int'(h_counter) == H_TOTAL - 1) ? wrap_inc(v_counter, V_TOTAL) : v_counter;
    assign tick_next = (int'(h_next) == H_TOTAL - 1) && (int'(v_next) == V_TOTAL - 1);

    vga_slot_locator #(
        .NUM_DIGITS (NUM_DIGITS),
        .DIGIT_W    (DIGIT_W),
        .DIGIT_H    (DIGIT_H),
        .GAP        (GAP),
        .ORIGIN_X   (ORIGIN_X),
        .ORIGIN_Y   (ORIGIN_Y),
        .SLOT_W     (SLOT_W)
    ) u_locator (
        .h_next (h_next),
        .v_next (v_next),
        .slot   (slot),
        .in_box (in_box),
        .slot_x (slot_x)
    );

    assign digit = active_word[WORD_W - 4 - 4 * int'(slot) +: 4];

    // lead_zero[k]: slot k and every more-significant slot hold zero.
    always_comb begin
        logic zero_run;
        zero_run  = 1'b1;
        lead_zero = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            zero_run     = zero_run && (active_word[WORD_W - 4 - 4 * k +: 4] == 4'd0);
            lead_zero[k] = zero_run;
        end
    end

    assign blank = (digit > 4'd9)
                || (blink_en && blink_mask[NUM_DIGITS - 1 - int'(slot)] && !blink_on)
                || (lz_suppress && lead_zero[slot] && (int'(slot) != NUM_DIGITS - 1));

    // Load FSM: state register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) state <= LOAD_IDLE;
        else     state <= state_nxt;
    end

    // Load FSM: next state.
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD_IDLE:    if (wr_valid)   state_nxt = LOAD_PENDING;
            LOAD_PENDING: if (frame_tick) state_nxt = LOAD_IDLE;
        endcase
    end

    // Load FSM: outputs.
    always_comb begin
        wr_ready = (state == LOAD_IDLE);
        capture  = (state == LOAD_IDLE) && wr_valid;
        commit   = (state == LOAD_PENDING) && frame_tick;
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the digit registers are reset as well, so a word pending at reset is dropped.
        if (rst) begin
            shadow_word <= '0;
            active_word <= '0;
        end else begin
            if (capture) shadow_word <= wr_data;
            if (commit)  active_word <= shadow_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (frame_tick) begin
            if (int'(blink_cnt) == BLINK_FRAMES - 1) begin
                blink_cnt <= '0;
                blink_on  <= !blink_on;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable     <= 1'b0;
            bcd        <= 4'd0;
            h_start    <= 10'(ORIGIN_X);
            v_start    <= 10'(ORIGIN_Y);
            frame_tick <= 1'b0;
        end else begin
            enable     <= in_box && !blank;
            bcd        <= (in_box && !blank) ? digit : 4'd0;
            h_start    <= slot_x;
            v_start    <= 10'(ORIGIN_Y);
            frame_tick <= tick_next;
        end
    end

    assign h_size = 10'(DIGIT_W);
    assign v_size = 10'(DIGIT_H);

endmodule

// File: tb/tb_vga_digit_sched.sv
// Self-checking bench for vga_digit_sched: directed scenarios plus random
// pixels and writes, compared every cycle against a behavioural model.
module tb_vga_digit_sched;

    localparam int N     = 4;
    localparam int DW    = 40;
    localparam int DH    = 60;
    localparam int GP    = 20;
    localparam int OX    = 200;
    localparam int OY    = 200;
    localparam int BF    = 30;
    localparam int PITCH = DW + GP;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  h_counter = '0;
    logic [9:0]  v_counter = '0;
    logic        wr_valid = 1'b0;
    logic [15:0] wr_data = '0;
    logic        wr_ready;
    logic        blink_en = 1'b0;
    logic [3:0]  blink_mask = '0;
    logic        lz_suppress = 1'b0;
    logic        enable;
    logic [3:0]  bcd;
    logic [9:0]  h_start, v_start, h_size, v_size;
    logic        frame_tick;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Behavioural model state and the outputs it predicts for the current cycle.
    logic [15:0] m_active, m_shadow;
    bit          m_pending;
    int          m_ticks;
    logic        e_enable;
    logic [3:0]  e_bcd;
    logic [9:0]  e_h_start;
    logic        e_ft;
    logic        e_ready;

    always #5 clk = ~clk;

    vga_digit_sched #(
        .NUM_DIGITS(N), .DIGIT_W(DW), .DIGIT_H(DH), .GAP(GP),
        .ORIGIN_X(OX), .ORIGIN_Y(OY), .BLINK_FRAMES(BF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .h_counter   (h_counter),
        .v_counter   (v_counter),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .blink_en    (blink_en),
        .blink_mask  (blink_mask),
        .lz_suppress (lz_suppress),
        .enable      (enable),
        .bcd         (bcd),
        .h_start     (h_start),
        .v_start     (v_start),
        .h_size      (h_size),
        .v_size      (v_size),
        .frame_tick  (frame_tick)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active  = '0;
        m_shadow  = '0;
        m_pending = 1'b0;
        m_ticks   = 0;
        e_enable  = 1'b0;
        e_bcd     = '0;
        e_h_start = 10'(OX);
        e_ft      = 1'b0;
        e_ready   = 1'b1;
    endtask

    function automatic int nibble(input logic [15:0] word, input int k);
        return int'((word >> (4 * (N - 1 - k))) & 16'hF);
    endfunction

    function automatic bit digit_blank(input int k, input logic [15:0] word, input int ticks);
        bit phase_off;
        phase_off = ((ticks / BF) % 2) == 1;
        if (nibble(word, k) > 9) return 1'b1;
        if (blink_en && blink_mask[N - 1 - k] && phase_off) return 1'b1;
        if (lz_suppress && (k < N - 1) && ((word >> (4 * (N - 1 - k))) == 16'd0)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_edge();
        int nh, nv, k, r;
        bit inbox, tick_now;
        nh = int'(h_counter) + 1;
        nv = int'(v_counter);
        if (nh == 800) begin
            nh = 0;
            nv = (nv + 1) % 525;
        end
        inbox = 1'b0;
        k = 0;
        if (nh >= OX && nv >= OY && nv <= OY + DH) begin
            k = (nh - OX) / PITCH;
            r = (nh - OX) % PITCH;
            inbox = (k < N) && (r <= DW);
        end
        if (inbox && !digit_blank(k, m_active, m_ticks)) begin
            e_enable = 1'b1;
            e_bcd    = 4'(nibble(m_active, k));
        end else begin
            e_enable = 1'b0;
            e_bcd    = 4'd0;
        end
        e_h_start = inbox ? 10'(OX + k * PITCH) : 10'(OX);
        e_ft      = (nh == 799) && (nv == 524);
        tick_now  = (h_counter == 10'd799) && (v_counter == 10'd524);
        if (!m_pending) begin
            if (wr_valid) begin
                m_shadow  = wr_data;
                m_pending = 1'b1;
            end
        end else if (tick_now) begin
            m_active  = m_shadow;
            m_pending = 1'b0;
        end
        if (tick_now) m_ticks++;
        e_ready = !m_pending;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_edge();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("enable",     enable,     e_enable);
            check("bcd",        bcd,        e_bcd);
            check("h_start",    h_start,    e_h_start);
            check("v_start",    v_start,    OY);
            check("h_size",     h_size,     DW);
            check("v_size",     v_size,     DH);
            check("frame_tick", frame_tick, e_ft);
            check("wr_ready",   wr_ready,   e_ready);
        end
    end

    task automatic pix(input int h, input int v);
        @(negedge clk);
        h_counter = 10'(h);
        v_counter = 10'(v);
    endtask

    task automatic frame_end();
        pix(798, 524);
        pix(799, 524);
        pix(0, 0);
    endtask

    task automatic offer(input logic [15:0] w);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = w;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // Drive the pixel just left of slot's column 10 and check the registered result.
    task automatic look(input string name, input int slot, input bit en, input logic [3:0] b);
        pix(OX + slot * PITCH + 9, OY + 30);
        @(posedge clk);
        #1;
        check({name, "_en"},  enable, en);
        check({name, "_bcd"}, bcd,    b);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_enable",  enable,     0);
        check("rst_bcd",     bcd,        0);
        check("rst_h_start", h_start,    OX);
        check("rst_v_start", v_start,    OY);
        check("rst_h_size",  h_size,     DW);
        check("rst_ft",      frame_tick, 0);
        check("rst_ready",   wr_ready,   1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 2000000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();
        chk_en = 1'b1;

        // Load and render 1234.
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = 16'h1234;
        @(posedge clk);
        #1;
        check("ready_after_write", wr_ready, 0);
        @(negedge clk);
        wr_valid = 1'b0;
        pix(220, 230);
        @(posedge clk); #1;
        check("pre_commit_en",  enable, 1);
        check("pre_commit_bcd", bcd,    0);
        frame_end();
        pix(220, 230);
        @(posedge clk); #1;
        check("p221_en",  enable,  1);
        check("p221_bcd", bcd,     1);
        check("p221_hs",  h_start, 200);
        pix(260, 230);
        @(posedge clk); #1;
        check("p261_bcd", bcd,     2);
        check("p261_hs",  h_start, 260);
        pix(249, 230);
        @(posedge clk); #1;
        check("p250_en",  enable,  0);
        check("p250_hs",  h_start, 200);

        // Leading-zero suppression.
        lz_suppress = 1'b1;
        offer(16'h0045);
        frame_end();
        look("lz45_s0", 0, 0, 0);
        look("lz45_s1", 1, 0, 0);
        look("lz45_s2", 2, 1, 4);
        look("lz45_s3", 3, 1, 5);
        offer(16'h0000);
        frame_end();
        look("lz00_s0", 0, 0, 0);
        look("lz00_s1", 1, 0, 0);
        look("lz00_s2", 2, 0, 0);
        look("lz00_s3", 3, 1, 0);
        lz_suppress = 1'b0;

        // Write while pending is dropped; write on frame_tick commits one frame later.
        offer(16'h1111);
        offer(16'h9999);
        frame_end();
        look("keep_first", 0, 1, 1);
        pix(798, 524);
        @(negedge clk);
        h_counter = 10'd799;
        wr_valid  = 1'b1;
        wr_data   = 16'h2222;
        @(negedge clk);
        wr_valid  = 1'b0;
        h_counter = 10'd0;
        v_counter = 10'd0;
        @(posedge clk); #1;
        check("coincident_pending", wr_ready, 0);
        look("coincident_not_yet", 0, 1, 1);
        frame_end();
        look("coincident_later", 0, 1, 2);

        // Invalid nibble, then reset while a word is pending.
        offer(16'h1B34);
        frame_end();
        look("nibble_b", 1, 0, 0);
        look("nibble_b_nbr", 0, 1, 1);
        offer(16'h5555);
        pix(220, 230);
        @(posedge clk); #1;
        check("pre_rst_en", enable, 1);
        do_reset();
        frame_end();
        frame_end();
        look("no_commit", 0, 1, 0);
        check("ready_after_rst", wr_ready, 1);

        // Blink phase: slot 3 on for frames 0-29, off 30-59, on again at 60.
        do_reset();
        blink_en   = 1'b1;
        blink_mask = 4'b0001;
        for (int f = 0; f < 62; f++) begin
            look("blink_s3", 3, (f < 30) || (f >= 60), 0);
            look("blink_s0", 0, 1, 0);
            frame_end();
        end
        blink_en = 1'b0;

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) frame_end();
            if ($urandom_range(0, 99) < 3) begin
                blink_en    = 1'($urandom_range(0, 1));
                blink_mask  = 4'($urandom);
                lz_suppress = 1'($urandom_range(0, 1));
            end
            wr_valid = ($urandom_range(0, 19) == 0);
            wr_data  = 16'($urandom);
            if ($urandom_range(0, 1) == 1) wr_data = wr_data >> (4 * $urandom_range(1, 4));
            if ($urandom_range(0, 3) == 0)
                pix($urandom_range(0, 797), $urandom_range(0, 524));
            else
                pix($urandom_range(OX - 5, OX + N * PITCH), $urandom_range(OY - 3, OY + DH + 3));
        end
        wr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_digit_sched.md
VGA_DIGIT_SCHED -- requirements
Module: vga_digit_sched

Interface
REQ-001 SHALL have parameters: NUM_DIGITS, default 4, digit slots on screen; DIGIT_W, default 40, glyph width in pixels; DIGIT_H, default 60, glyph height in lines; GAP, default 20, pixels between slots; ORIGIN_X, default 200, slot 0 left column; ORIGIN_Y, default 200, top line; BLINK_FRAMES, default 30, frames per blink phase.
REQ-002 SHALL have ports: clk in 1, pixel clock; rst in 1, reset, asynchronous, active-high.
REQ-003 SHALL have ports: h_counter in 10, current column 0..799; v_counter in 10, current line 0..524.
REQ-004 SHALL have ports: wr_valid in 1, new digit word offered; wr_data in 4*NUM_DIGITS, BCD digits, slot 0 = most significant nibble; wr_ready out 1, shadow register free.
REQ-005 SHALL have ports: blink_en in 1, blinking on; blink_mask in NUM_DIGITS, slots that blink; lz_suppress in 1, blank leading zeros.
REQ-006 SHALL have renderer-side outputs: enable out 1; bcd out 4; h_start, v_start, h_size, v_size out 10 each; frame_tick out 1, one-cycle pulse at frame end.

Function
REQ-007 SHALL share one digit renderer among NUM_DIGITS slots; slot k spans columns ORIGIN_X+k*(DIGIT_W+GAP) .. +DIGIT_W inclusive and lines ORIGIN_Y .. ORIGIN_Y+DIGIT_H inclusive.
REQ-008 SHALL register all renderer outputs; they are computed for the next pixel (h_counter+1, wrapping 799->0 with v_counter+1, 524->0), so they are valid while the renderer samples that pixel.
REQ-009 SHALL drive h_size=DIGIT_W and v_size=DIGIT_H constantly; h_start/v_start SHALL be the active slot origin, else the slot 0 origin.
REQ-010 SHALL drive enable=1 and bcd=active digit only inside a slot box and when the digit is not blanked; outside every box enable=0 and bcd=0.
REQ-011 SHALL blank a digit when its value is >9, when blink_en=1, its blink_mask bit=1 and the blink phase is OFF, or when lz_suppress=1 and it is a zero with all more-significant digits also zero; the least significant slot SHALL never be zero-suppressed.
REQ-012 SHALL pulse frame_tick for exactly one cycle when h_counter=799 and v_counter=524.
REQ-013 Load FSM states: IDLE (wr_ready=1), PENDING (wr_ready=0). IDLE with wr_valid=1 -> capture wr_data into shadow, go PENDING. PENDING at frame_tick -> copy shadow to active digits, go IDLE.
REQ-014 Active digits SHALL change only on frame_tick (no tearing); wr_valid during PENDING SHALL be ignored and not captured.
REQ-015 wr_valid in IDLE coinciding with frame_tick SHALL be captured to shadow and committed at the following frame_tick, not the current one.
REQ-016 Blink frame counter SHALL count frame_tick pulses 0..BLINK_FRAMES-1, wrap to 0 and toggle the blink phase on wrap; phase starts ON; counter runs regardless of blink_en.

Reset
REQ-017 rst=1 SHALL immediately force: enable=0, bcd=0, h_start=ORIGIN_X, v_start=ORIGIN_Y, h_size=DIGIT_W, v_size=DIGIT_H, frame_tick=0, wr_ready=1, FSM IDLE, active and shadow digits 0, blink counter 0, phase ON.
REQ-018 rst asserted while PENDING SHALL discard the shadow word; no commit occurs after release.

Structure
REQ-019 Shared package SHALL hold VGA timing constants (H_TOTAL=800, V_TOTAL=525) and the FSM state encoding.
REQ-020 One sub-module is natural: vga_slot_locator (pure combinational mapping of next-pixel coordinates to slot index and in-box flag); everything else in vga_digit_sched.

Verification
REQ-021 Reset, then wr_data=16'h1234 with wr_valid for one cycle -> wr_ready=0 next cycle; active digits stay 0 until frame_tick; next frame pixel (221,230) -> enable=1, bcd=1, h_start=200; pixel (261,230) -> bcd=2, h_start=260; pixel (250,230) -> enable=0.
REQ-022 wr_data=16'h0045, lz_suppress=1 -> slots 0,1 enable=0; slot 2 bcd=4; wr_data=16'h0000 -> only slot 3 enabled, bcd=0.
REQ-023 blink_en=1, blink_mask=4'b0001 -> slot 3 enabled frames 0-29, blanked frames 30-59, enabled again frame 60; other slots always enabled.
REQ-024 Second wr_valid (16'h9999) while PENDING -> ignored; commit shows the first word; wr_valid coincident with frame_tick -> commit one frame later.
REQ-025 Digit nibble 4'hB -> that slot enable=0; rst pulsed while PENDING with 16'h5555 -> all outputs at reset values immediately, no commit after release.
